// File: rtl/close_path_pipe.sv
// Close-path effective subtraction for the dual-path FP adder.
// Three registered stages: subtract/abs, normalise, round/flag.
module close_path_pipe #(
    parameter int SIZE_MANTISSA = 24,
    parameter int SIZE_EXPONENT = 8,
    parameter int SIZE_COUNTER  = 5,
    parameter int TAG_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE_MANTISSA-1:0] m_a,
    input  logic [SIZE_MANTISSA-1:0] m_b,
    input  logic [SIZE_EXPONENT-1:0] exp_a,
    input  logic                     exp_difference,
    input  logic                     sign_a,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE_MANTISSA-1:0] m_o,
    output logic [SIZE_EXPONENT-1:0] e_o,
    output logic                     s_o,
    output logic                     zero_o,
    output logic                     uf_o,
    output logic                     ovf_o,
    output logic [TAG_W-1:0]         tag_o
);

    localparam int M = SIZE_MANTISSA;
    localparam int E = SIZE_EXPONENT;
    localparam int C = SIZE_COUNTER;
    localparam int T = TAG_W;

    // Post-round exponent carries two extra bits: sign plus room for +1.
    localparam logic signed [E+1:0] EX_ONE = (E+2)'(1);
    localparam logic signed [E+1:0] EX_MAX = (E+2)'((2**E) - 1);

    // Stage valids and the collapsing ready chain.
    logic v1_q, v2_q, v3_q;
    logic rdy1, rdy2, rdy3;

    assign rdy3     = ~v3_q | out_ready;
    assign rdy2     = ~v2_q | rdy3;
    assign rdy1     = ~v1_q | rdy2;
    assign in_ready = rdy1;

    // ---------------- Stage 1: subtract and take magnitude
    logic [M:0]   a_ext, b_ext;
    logic [M+1:0] diff;
    logic [M:0]   mag_d;
    logic         neg_d;

    logic [M:0]   mag1_q;
    logic         neg1_q;
    logic [E-1:0] exp1_q;
    logic         sgn1_q;
    logic [T-1:0] tag1_q;

    // Aligned subtraction; |D| always fits in M+1 bits.
    always_comb begin
        a_ext = {m_a, 1'b0};
        b_ext = exp_difference ? {1'b0, m_b} : {m_b, 1'b0};
        diff  = {1'b0, a_ext} - {1'b0, b_ext};
        neg_d = diff[M+1];
        mag_d = neg_d ? (~diff[M:0] + (M+1)'(1)) : diff[M:0];
    end

    // Stage 1 register: loads whenever it is empty or draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            mag1_q <= '0;
            neg1_q <= 1'b0;
            exp1_q <= '0;
            sgn1_q <= 1'b0;
            tag1_q <= '0;
        end else if (rdy1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                mag1_q <= mag_d;
                neg1_q <= neg_d;
                exp1_q <= exp_a;
                sgn1_q <= sign_a;
                tag1_q <= tag_i;
            end
        end
    end

    // ---------------- Stage 2: leading-zero count and normalise
    logic [C-1:0] lz;
    logic         lz_found;
    logic [M:0]   norm_d;
    logic         zero_d;
    logic [E:0]   ex_d;

    logic [M:0]   norm2_q;
    logic         zero2_q;
    logic [E:0]   ex2_q;
    logic         neg2_q;
    logic         sgn2_q;
    logic [T-1:0] tag2_q;

    // Priority scan from the MSB; an all-zero magnitude gives M+1.
    always_comb begin
        lz       = C'(M + 1);
        lz_found = 1'b0;
        for (int i = M; i >= 0; i--) begin
            if (!lz_found && mag1_q[i]) begin
                lz       = C'(M - i);
                lz_found = 1'b1;
            end
        end
        norm_d = mag1_q << lz;
        zero_d = (mag1_q == '0);
        ex_d   = {1'b0, exp1_q} - {{(E + 1 - C){1'b0}}, lz};
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            norm2_q <= '0;
            zero2_q <= 1'b0;
            ex2_q   <= '0;
            neg2_q  <= 1'b0;
            sgn2_q  <= 1'b0;
            tag2_q  <= '0;
        end else if (rdy2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                norm2_q <= norm_d;
                zero2_q <= zero_d;
                ex2_q   <= ex_d;
                neg2_q  <= neg1_q;
                sgn2_q  <= sgn1_q;
                tag2_q  <= tag1_q;
            end
        end
    end

    // ---------------- Stage 3: round to nearest-even and flag
    logic                 rnd_up;
    logic [M:0]           mant_sum;
    logic                 rnd_carry;
    logic signed [E+1:0]  exr;
    logic [M-1:0]         m_d;
    logic [E-1:0]         e_d;
    logic                 s_d;
    logic                 z_d;
    logic                 uf_d;
    logic                 ovf_d;

    logic [M-1:0]         m3_q;
    logic [E-1:0]         e3_q;
    logic                 s3_q;
    logic                 z3_q;
    logic                 uf3_q;
    logic                 ovf3_q;
    logic [T-1:0]         tag3_q;

    // Sticky is always 0 here, so a round bit set is a tie.
    always_comb begin
        rnd_up    = norm2_q[0] & norm2_q[1];
        mant_sum  = {1'b0, norm2_q[M:1]} + {{M{1'b0}}, rnd_up};
        rnd_carry = mant_sum[M];
        exr       = {ex2_q[E], ex2_q} + {{(E + 1){1'b0}}, rnd_carry};
        m_d   = rnd_carry ? {1'b1, {(M - 1){1'b0}}} : mant_sum[M-1:0];
        e_d   = exr[E-1:0];
        s_d   = sgn2_q ^ neg2_q;
        z_d   = 1'b0;
        uf_d  = 1'b0;
        ovf_d = 1'b0;
        if (zero2_q) begin
            m_d = '0;
            e_d = '0;
            s_d = 1'b0;
            z_d = 1'b1;
        end else if (exr < EX_ONE) begin
            m_d  = '0;
            e_d  = '0;
            uf_d = 1'b1;
        end else if (exr >= EX_MAX) begin
            m_d   = '0;
            e_d   = '1;
            ovf_d = 1'b1;
        end
    end

    // Stage 3 register drives the outputs; it holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            m3_q   <= '0;
            e3_q   <= '0;
            s3_q   <= 1'b0;
            z3_q   <= 1'b0;
            uf3_q  <= 1'b0;
            ovf3_q <= 1'b0;
            tag3_q <= '0;
        end else if (rdy3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                m3_q   <= m_d;
                e3_q   <= e_d;
                s3_q   <= s_d;
                z3_q   <= z_d;
                uf3_q  <= uf_d;
                ovf3_q <= ovf_d;
                tag3_q <= tag2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign m_o       = m3_q;
    assign e_o       = e3_q;
    assign s_o       = s3_q;
    assign zero_o    = z3_q;
    assign uf_o      = uf3_q;
    assign ovf_o     = ovf3_q;
    assign tag_o     = tag3_q;

endmodule

// File: tb/tb_close_path_pipe.sv
// Bench for close_path_pipe: directed vector table plus
// stall, ordering and mid-stream reset sequences.
module tb_close_path_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] m_a, m_b;
    logic [7:0]  exp_a;
    logic        exp_difference;
    logic        sign_a;
    logic [3:0]  tag_i;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] m_o;
    logic [7:0]  e_o;
    logic        s_o, zero_o, uf_o, ovf_o;
    logic [3:0]  tag_o;

    int tests = 0;
    int fails = 0;

    close_path_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .m_a(m_a), .m_b(m_b), .exp_a(exp_a),
        .exp_difference(exp_difference), .sign_a(sign_a),
        .tag_i(tag_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .m_o(m_o), .e_o(e_o), .s_o(s_o),
        .zero_o(zero_o), .uf_o(uf_o), .ovf_o(ovf_o),
        .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ma;
        logic [23:0] mb;
        logic        ed;
        logic [7:0]  ex;
        logic        sg;
        logic [23:0] xm;
        logic [7:0]  xe;
        logic        xs;
        logic        xz;
        logic        xuf;
        logic        xovf;
    } vec_t;

    localparam int NV = 16;
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] pack_out();
        return {m_o, e_o, s_o, zero_o, uf_o, ovf_o, tag_o};
    endfunction

    task automatic drive(input logic [23:0] ma, input logic [23:0] mb,
                         input logic ed, input logic [7:0] ex,
                         input logic sg, input logic [3:0] tg);
        m_a = ma; m_b = mb; exp_difference = ed;
        exp_a = ex; sign_a = sg; tag_i = tg;
    endtask

    int lat;
    int sent, got, cyc, extra;
    bit saw_low, have_prev;
    logic [39:0] prev;

    initial begin
        vt[0]  = '{24'hC00000, 24'h800000, 0, 8'd127, 0,
                   24'h800000, 8'd126, 0, 0, 0, 0};
        vt[1]  = '{24'hA5A5A5, 24'hA5A5A5, 0, 8'd90, 1,
                   24'h000000, 8'd0, 0, 1, 0, 0};
        vt[2]  = '{24'h800000, 24'hFFFFFF, 1, 8'd128, 0,
                   24'h800000, 8'd104, 0, 0, 0, 0};
        vt[3]  = '{24'h800000, 24'hFFFFFF, 1, 8'd10, 0,
                   24'h000000, 8'd0, 0, 0, 1, 0};
        vt[4]  = '{24'h800000, 24'hC00000, 0, 8'd127, 0,
                   24'h800000, 8'd126, 1, 0, 0, 0};
        vt[5]  = '{24'hFFFFFF, 24'h800001, 1, 8'd100, 0,
                   24'hBFFFFE, 8'd100, 0, 0, 0, 0};
        vt[6]  = '{24'hFFFFFF, 24'h800003, 1, 8'd100, 1,
                   24'hBFFFFE, 8'd100, 1, 0, 0, 0};
        vt[7]  = '{24'hFFFFFF, 24'h800001, 1, 8'd255, 0,
                   24'h000000, 8'hFF, 0, 0, 0, 1};
        vt[8]  = '{24'h800000, 24'hFFFFFF, 1, 8'd25, 0,
                   24'h800000, 8'd1, 0, 0, 0, 0};
        vt[9]  = '{24'h800000, 24'hFFFFFF, 1, 8'd24, 1,
                   24'h000000, 8'd0, 1, 0, 1, 0};
        vt[10] = '{24'hC00000, 24'h800000, 0, 8'd255, 0,
                   24'h800000, 8'd254, 0, 0, 0, 0};
        vt[11] = '{24'hC00000, 24'h800000, 0, 8'd127, 1,
                   24'h800000, 8'd126, 1, 0, 0, 0};
        vt[12] = '{24'h800000, 24'hC00000, 0, 8'd127, 1,
                   24'h800000, 8'd126, 0, 0, 0, 0};
        vt[13] = '{24'h800000, 24'h800000, 1, 8'd50, 0,
                   24'h800000, 8'd49, 0, 0, 0, 0};
        vt[14] = '{24'hF0F0F0, 24'hF00000, 0, 8'd130, 0,
                   24'hF0F000, 8'd122, 0, 0, 0, 0};
        vt[15] = '{24'hFFFFFF, 24'h800001, 1, 8'd254, 0,
                   24'hBFFFFE, 8'd254, 0, 0, 0, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(24'h0, 24'h0, 1'b0, 8'h0, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_data", 64'(pack_out()), 64'd0);
        rst_n = 1'b1;

        // Single-op vectors: latency and result per record.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].ma, vt[i].mb, vt[i].ed, vt[i].ex,
                  vt[i].sg, 4'(i));
            in_valid = 1'b1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
            lat = 0;
            @(posedge clk); lat++;
            @(negedge clk);
            in_valid = 1'b0;
            while (!out_valid && lat < 10) begin
                @(posedge clk); lat++;
                @(negedge clk);
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("vec%0d_result", i), 64'(pack_out()),
                64'({vt[i].xm, vt[i].xe, vt[i].xs, vt[i].xz,
                     vt[i].xuf, vt[i].xovf, 4'(i)}));
        end
        @(posedge clk);

        // Eight back-to-back ops with a consumer stall on cycles 4-9.
        sent = 0; got = 0; cyc = 0;
        saw_low = 0; have_prev = 0; prev = '0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 9);
            in_valid = (sent < 8);
            drive(24'hC00000, 24'h800000, 1'b0, 8'(100 + sent),
                  1'b0, 4'(sent));
            #1;
            if (!in_ready) saw_low = 1;
            if (out_valid && have_prev)
                chk("stall_hold", 64'(pack_out()), 64'(prev));
            have_prev = 0;
            if (out_valid && !out_ready) begin
                prev = pack_out();
                have_prev = 1;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d", got), 64'(pack_out()),
                    64'({24'h800000, 8'(99 + got), 4'b0000,
                         4'(got)}));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream_count", 64'(got), 64'd8);
        chk("stream_sent", 64'(sent), 64'd8);
        chk("stream_no_dup", 64'(extra), 64'd0);
        chk("stream_backpressure", 64'(saw_low), 64'd1);

        // Reset with ops in flight discards them.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(24'hC00000, 24'h800000, 1'b0, 8'd127, 1'b1, 4'(i));
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_data", 64'(pack_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(24'hC00000, 24'h800000, 1'b0, 8'd127, 1'b0, 4'd9);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        got = 0;
        repeat (8) begin
            if (out_valid) begin
                got++;
                chk("rst_after_result", 64'(pack_out()),
                    64'({24'h800000, 8'd126, 4'b0000, 4'd9}));
            end
            @(negedge clk);
        end
        chk("rst_after_count", 64'(got), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
